// File: rtl/top_cnt_pkg.sv
// Shared widths and defaults for the top_cnt prescaled modulo counter.
// No logic beyond the counter-step helper.
`timescale 1ns/1ps
package top_cnt_pkg;

  localparam int CNT_MOD_DEF = 60;
  localparam int OUT_W       = 6;
  localparam int PSC_W       = 32;

  // Modulo increment: wraps straight from last to zero.
  function automatic logic [OUT_W-1:0] cnt_next(input logic [OUT_W-1:0] cur,
                                                input logic [OUT_W-1:0] last);
    return (cur == last) ? '0 : cur + OUT_W'(1);
  endfunction

endpackage

// File: rtl/top_cnt_nco.sv
// Prescaler: tick (combinational enable) when psc >= num-1 or num <= 1; psc clears on tick.
// No backpressure; TOP_CNT_NUM_RESYNC_EN restarts the period and masks tick on a num change.
`timescale 1ns/1ps
module top_cnt_nco
  import top_cnt_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PSC_W-1:0] num,
  output logic             tick
);

  logic [PSC_W-1:0] r_psc;
  logic             w_tick_raw;
  logic             w_psc_clr;

  // The num <= 1 term also protects against num-1 underflowing when num is 0.
  assign w_tick_raw = (num <= PSC_W'(1)) || (r_psc >= (num - PSC_W'(1)));

`ifdef TOP_CNT_NUM_RESYNC_EN
  logic [PSC_W-1:0] r_num_prev;
  logic             r_num_vld;
  logic             w_num_chg;

  // r_num_vld keeps the first edge after reset from reading as a change.
  assign w_num_chg = r_num_vld && (num != r_num_prev);
  assign tick      = w_tick_raw && !w_num_chg;
  assign w_psc_clr = w_tick_raw || w_num_chg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num_prev <= '0;
      r_num_vld  <= 1'b0;
    end else begin
      r_num_prev <= num;
      r_num_vld  <= 1'b1;
    end
  end
`else
  assign tick      = w_tick_raw;
  assign w_psc_clr = w_tick_raw;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_psc <= '0;
    end else if (w_psc_clr) begin
      r_psc <= '0;
    end else begin
      r_psc <= r_psc + PSC_W'(1);
    end
  end

endmodule

// File: rtl/top_cnt.sv
// Modulo-CNT_MOD counter advanced once every num clk cycles; out first steps on edge num after reset.
// No backpressure; optional num-change resync via TOP_CNT_NUM_RESYNC_EN in top_cnt_nco.
`timescale 1ns/1ps
module top_cnt
  import top_cnt_pkg::*;
#(
  parameter int CNT_MOD = CNT_MOD_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PSC_W-1:0] num,
  output logic [OUT_W-1:0] out
);

  localparam logic [OUT_W-1:0] LP_LAST = OUT_W'(CNT_MOD - 1);

  logic             w_tick;
  logic [OUT_W-1:0] r_out;

  top_cnt_nco u_nco (
    .clk   (clk),
    .rst_n (rst_n),
    .num   (num),
    .tick  (w_tick)
  );

  // Tick is a clock enable; the counter stays in the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
    end else if (w_tick) begin
      r_out <= cnt_next(r_out, LP_LAST);
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_top_cnt.sv
// Directed bench for top_cnt: latency, num 0/1, wrap, async reset, num change (default build).
`timescale 1ns/1ps
module tb_top_cnt;

  logic        clk;
  logic        rst_n;
  logic [31:0] num;
  logic [5:0]  out;

  int n_chk;
  int n_err;

  top_cnt #(.CNT_MOD(60)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .num   (num),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1ns past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset asserted for one full cycle, released on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_out", {26'd0, out}, 32'd0);
    chk("rst_psc", dut.u_nco.r_psc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    num   = 32'd5;
    #1;
    chk("por_out", {26'd0, out}, 32'd0);

    // num=5: out holds 0 through edge 4, 1 at edge 5, 2 at edge 10.
    do_reset();
    for (int e = 1; e <= 4; e++) begin
      step(1);
      chk("n5_hold", {26'd0, out}, 32'd0);
    end
    chk("n5_psc4", dut.u_nco.r_psc, 32'd4);
    step(1);
    chk("n5_e5", {26'd0, out}, 32'd1);
    chk("n5_psc0", dut.u_nco.r_psc, 32'd0);
    step(5);
    chk("n5_e10", {26'd0, out}, 32'd2);

    // num=1: one step per edge, wrap 59 -> 0 at edge 60.
    num = 32'd1;
    do_reset();
    for (int e = 1; e <= 60; e++) begin
      step(1);
      chk("n1_trace", {26'd0, out}, 32'(e % 60));
    end

    // num=0 behaves like num=1.
    num = 32'd0;
    do_reset();
    for (int e = 1; e <= 60; e++) begin
      step(1);
      chk("n0_trace", {26'd0, out}, 32'(e % 60));
    end
    step(1);
    chk("n0_after_wrap", {26'd0, out}, 32'd1);

    // num=3: reach out=37 at edge 111, then reset asynchronously mid-cycle.
    num = 32'd3;
    do_reset();
    step(111);
    chk("n3_e111", {26'd0, out}, 32'd37);
    step(1);
    chk("n3_psc1", dut.u_nco.r_psc, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out", {26'd0, out}, 32'd0);
    chk("async_psc", dut.u_nco.r_psc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    chk("n3_post_e2", {26'd0, out}, 32'd0);
    step(1);
    chk("n3_post_e3", {26'd1, out} & 32'h3f, 32'd1);

    // num=10, change to 3 when psc=7: tick on next edge, then every 3.
    num = 32'd10;
    do_reset();
    step(7);
    chk("chg_psc7", dut.u_nco.r_psc, 32'd7);
    chk("chg_out0", {26'd0, out}, 32'd0);
    @(negedge clk);
    num = 32'd3;
    step(1);
    chk("chg_tick", {26'd0, out}, 32'd1);
    chk("chg_psc0", dut.u_nco.r_psc, 32'd0);
    step(2);
    chk("chg_hold", {26'd0, out}, 32'd1);
    step(1);
    chk("chg_p3", {26'd0, out}, 32'd2);
    step(3);
    chk("chg_p6", {26'd0, out}, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
